// File: rtl/aes_defs.sv
// Shared AES definitions for the inverse-cipher slice.
// Holds the AES-128 round count, the state width, the controller FSM encoding,
// the inverse S-box table and the GF(2^8) helpers used by InvMixColumns.
package aes_defs;

  localparam int unsigned NR_128  = 10;
  localparam int unsigned STATE_W = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StFinal = 2'd2
  } fsm_e;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Ports:
//   state      in   128  current cipher state (bit 127 = byte 0, column-major)
//   round_key  in   128  round key for this round
//   last       in   1    final round: bypass InvMixColumns
//   state_out  out  128  next state
module inv_round
  import aes_defs::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] round_key,
  input  logic               last,
  output logic [STATE_W-1:0] state_out
);

  logic [7:0] ark [16];
  logic [7:0] mix [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      // Byte i sits at row i%4, column i/4; InvShiftRows pulls it from column (c - r) mod 4.
      ark[i] = inv_sbox(state[127 - 8 * (4 * ((i / 4 + 4 - i % 4) % 4) + i % 4) -: 8])
               ^ round_key[127 - 8 * i -: 8];
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mix[4*c+0] = gmul14(ark[4*c]) ^ gmul11(ark[4*c+1]) ^ gmul13(ark[4*c+2]) ^ gmul9(ark[4*c+3]);
      mix[4*c+1] = gmul9(ark[4*c]) ^ gmul14(ark[4*c+1]) ^ gmul11(ark[4*c+2]) ^ gmul13(ark[4*c+3]);
      mix[4*c+2] = gmul13(ark[4*c]) ^ gmul9(ark[4*c+1]) ^ gmul14(ark[4*c+2]) ^ gmul11(ark[4*c+3]);
      mix[4*c+3] = gmul11(ark[4*c]) ^ gmul13(ark[4*c+1]) ^ gmul9(ark[4*c+2]) ^ gmul14(ark[4*c+3]);
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127 - 8 * i -: 8] = last ? ark[i] : mix[i];
    end
  end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse cipher, one round per clock.
// Sequences the initial AddRoundKey, NR-1 full inverse rounds and the final round,
// fetching round keys from an external expanded-key store via key_idx/round_key.
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous active-high reset
//   start      in   1       begin a block; only honoured when idle
//   data_in    in   128     ciphertext, sampled with start
//   round_key  in   128     key selected by key_idx, same cycle
//   key_idx    out  KIDX_W  round-key index wanted this cycle
//   busy       out  1       block in flight
//   done       out  1       one-cycle pulse when data_out updates
//   data_out   out  128     plaintext, held until the next completion
module inv_cipher_ctrl
  import aes_defs::*;
#(
  parameter int unsigned NR     = NR_128,
  parameter int unsigned KIDX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] data_in,
  input  logic [STATE_W-1:0] round_key,
  output logic [KIDX_W-1:0]  key_idx,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] data_out
);

  fsm_e               fsm_q;
  logic [KIDX_W-1:0]  rnd_q;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] round_out;
  logic               last;

  assign last = (fsm_q == StFinal);

  inv_round u_inv_round (
    .state     (state_q),
    .round_key (round_key),
    .last      (last),
    .state_out (round_out)
  );

  // Index depends only on registered state, so the key store sees a stable address.
  always_comb begin
    key_idx = KIDX_W'(NR);
    unique case (fsm_q)
      StIdle:  key_idx = KIDX_W'(NR);
      StRound: key_idx = rnd_q;
      StFinal: key_idx = '0;
      default: key_idx = KIDX_W'(NR);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= StIdle;
      rnd_q    <= '0;
      state_q  <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q <= data_in ^ round_key;
            rnd_q   <= KIDX_W'(NR - 1);
            busy    <= 1'b1;
            fsm_q   <= (NR == 1) ? StFinal : StRound;
          end
        end
        StRound: begin
          state_q <= round_out;
          rnd_q   <= rnd_q - KIDX_W'(1);
          if (rnd_q == KIDX_W'(1)) begin
            fsm_q <= StFinal;
          end
        end
        StFinal: begin
          data_out <= round_out;
          done     <= 1'b1;
          busy     <= 1'b0;
          fsm_q    <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          fsm_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl using FIPS-197 known answers.
// The expanded-key store is modelled here: the S-box is derived from GF(2^8)
// inversion plus the affine map, and the AES-128 key schedule is run at time zero.
module tb_inv_cipher_ctrl;

  localparam int NR     = 10;
  localparam int KIDX_W = 4;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic              clk;
  logic              reset;
  logic              start;
  logic [127:0]      data_in;
  logic [127:0]      round_key;
  logic [KIDX_W-1:0] key_idx;
  logic              busy;
  logic              done;
  logic [127:0]      data_out;

  int checks   = 0;
  int failures = 0;

  logic [127:0] rk [0:1][0:NR];
  logic         key_sel;

  inv_cipher_ctrl #(
    .NR     (NR),
    .KIDX_W (KIDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .round_key (round_key),
    .key_idx   (key_idx),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    round_key = '0;
    if (int'(key_idx) <= NR) round_key = rk[key_sel][int'(key_idx)];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] cand;
    for (int i = 1; i < 256; i++) begin
      cand = i[7:0];
      if (gmul(a, cand) == 8'h01) inv = cand;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key, input int sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one block and watch 14 edges after E0; optionally pulse start again at poke_edge.
  task automatic run_block(input logic [127:0] din, input logic ks, input int poke_edge,
                           input logic [127:0] poke_din, output int done_edge,
                           output int done_cnt, output logic kseq_ok, output logic busy_ok,
                           output logic [127:0] dout);
    done_edge = -1;
    done_cnt  = 0;
    kseq_ok   = 1'b1;
    busy_ok   = 1'b1;
    dout      = '0;
    key_sel   = ks;
    data_in   = din;
    start     = 1'b1;
    if (key_idx !== KIDX_W'(NR)) kseq_ok = 1'b0;
    tick();
    start   = 1'b0;
    data_in = 128'hdeadbeef_0badf00d_cafef00d_12345678;
    for (int e = 1; e <= 14; e++) begin
      if (done_edge < 0 && e <= NR && key_idx !== KIDX_W'(NR - e)) kseq_ok = 1'b0;
      if (e == poke_edge) begin
        start   = 1'b1;
        data_in = poke_din;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          dout      = data_out;
        end
      end
      if (busy !== (e < NR)) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int           de;
    int           dc;
    logic         kok;
    logic         bok;
    logic [127:0] dout;
    int           e1;
    int           e2;
    logic         hold_ok;
    int           extra;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    key_sel = 1'b0;
    expand(KEY_C1, 0);
    expand(KEY_B, 1);
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data_out", data_out, '0);
    chk("rst_key_idx", 128'(key_idx), 128'(NR));
    reset = 1'b0;
    tick();

    // Known answer C.1
    run_block(CT_C1, 1'b0, -1, '0, de, dc, kok, bok, dout);
    chk("c1_data", dout, PT_C1);
    chk("c1_latency", 128'(de), 128'(NR));
    chk("c1_done_count", 128'(dc), 128'(1));
    chk("c1_key_seq", 128'(kok), 128'(1));
    chk("c1_busy", 128'(bok), 128'(1));

    // Known answer App. B
    run_block(CT_B, 1'b1, -1, '0, de, dc, kok, bok, dout);
    chk("b_data", dout, PT_B);
    chk("b_latency", 128'(de), 128'(NR));
    chk("b_done_count", 128'(dc), 128'(1));
    chk("b_key_seq", 128'(kok), 128'(1));

    // Start while busy must be ignored
    run_block(CT_C1, 1'b0, 4, CT_B, de, dc, kok, bok, dout);
    chk("busy_start_data", dout, PT_C1);
    chk("busy_start_latency", 128'(de), 128'(NR));
    chk("busy_start_done_count", 128'(dc), 128'(1));
    chk("busy_start_key_seq", 128'(kok), 128'(1));
    chk("busy_start_busy", 128'(bok), 128'(1));

    // Back-to-back: restart in the done cycle
    key_sel = 1'b0;
    data_in = CT_C1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    e1    = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (done === 1'b1) begin
        e1 = e;
        break;
      end
    end
    chk("b2b_first_latency", 128'(e1), 128'(NR));
    chk("b2b_first_data", data_out, PT_C1);
    key_sel = 1'b1;
    data_in = CT_B;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    e2      = -1;
    hold_ok = 1'b1;
    dout    = '0;
    if (done !== 1'b0) hold_ok = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (e2 < 0 && data_out !== PT_C1) hold_ok = 1'b0;
      tick();
      if (done === 1'b1 && e2 < 0) begin
        e2   = e + 1;
        dout = data_out;
      end
    end
    chk("b2b_gap", 128'(e2), 128'(NR + 1));
    chk("b2b_second_data", dout, PT_B);
    chk("b2b_hold", 128'(hold_ok), 128'(1));

    // Reset mid-operation at E5
    key_sel = 1'b0;
    data_in = CT_C1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_data_out", data_out, '0);
    chk("midrst_key_idx", 128'(key_idx), 128'(NR));
    extra = 0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    chk("midrst_quiet", 128'(extra), 128'(0));
    run_block(CT_B, 1'b1, -1, '0, de, dc, kok, bok, dout);
    chk("midrst_after_data", dout, PT_B);
    chk("midrst_after_latency", 128'(de), 128'(NR));

    // Reset wins over start
    reset   = 1'b1;
    start   = 1'b1;
    key_sel = 1'b0;
    data_in = CT_C1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_vs_start_busy", 128'(busy), 128'(0));
    chk("rst_vs_start_key_idx", 128'(key_idx), 128'(NR));
    extra = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || key_idx !== KIDX_W'(NR)) extra++;
    end
    chk("rst_vs_start_idle", 128'(extra), 128'(0));
    chk("rst_vs_start_data_out", data_out, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
